// File: rtl/compress_ctrl.sv
// Coefficient compressor and LSB-first bit packer for d in {1,4,5,10,11}.
// Define COMPRESS_CTRL_RANGE_CHK_EN to flag accepted coefficients >= 3329.
module compress_ctrl (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [3:0]  i_d,
  input  logic [11:0] i_coeff,
  input  logic        i_coeff_valid,
  output logic        o_coeff_ready,
  output logic [7:0]  o_byte,
  output logic        o_byte_valid,
  input  logic        i_byte_ready,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic        o_range_err
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t      state;
  logic [3:0]  d;
  logic [7:0]  cnt;
  logic        cnt_term;
  logic        r_vld;
  logic [10:0] r_val;
  logic [23:0] acc;
  logic [4:0]  fill;

  logic        d_ok;
  logic [23:0] k;
  logic [35:0] prod;
  logic [35:0] rnd;
  logic [11:0] q;
  logic [11:0] mask;
  logic [10:0] y;
  logic        xfer;
  logic [4:0]  base;
  logic        absorb;
  logic [4:0]  fill_nxt;
  logic [23:0] acc_sh;
  logic [23:0] acc_nxt;
  logic        accept;

  always_comb begin
    d_ok = (i_d == 4'd1) || (i_d == 4'd4)
        || (i_d == 4'd5) || (i_d == 4'd10)
        || (i_d == 4'd11);
  end

  always_comb begin
    k = 24'h0;
    unique case (1'b1)
      d == 4'd1:  k = 24'h00275F;
      d == 4'd4:  k = 24'h013AFB;
      d == 4'd5:  k = 24'h0275F7;
      d == 4'd10: k = 24'h4EBEDE;
      d == 4'd11: k = 24'h9D7DBB;
      default:    k = 24'h0;
    endcase
  end

  // Round-to-nearest via fixed-point reciprocal of q = 3329.
  always_comb begin
    prod = 36'(i_coeff) * 36'(k);
    rnd  = prod + 36'h000800000;
    q    = 12'(rnd >> 24);
    mask = (12'd1 << d) - 12'd1;
    y    = 11'(q & mask);
  end

  assign o_byte_valid = (fill >= 5'd8);
  assign o_byte       = acc[7:0];

  // A byte leaving frees room so the pending value can merge lower.
  always_comb begin
    xfer     = o_byte_valid && i_byte_ready;
    base     = xfer ? (fill - 5'd8) : fill;
    absorb   = r_vld && (base < 5'd8);
    fill_nxt = base + (absorb ? {1'b0, d} : 5'd0);
    acc_sh   = xfer ? {8'h00, acc[23:8]} : acc;
    acc_nxt  = acc_sh;
    if (absorb) begin
      acc_nxt = acc_sh | ({13'h0, r_val} << base);
    end
  end

  assign o_coeff_ready = (state == RUN) && !cnt_term
                      && (!r_vld || absorb);
  assign accept = o_coeff_ready && i_coeff_valid;

`ifdef COMPRESS_CTRL_RANGE_CHK_EN
  logic range_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      range_q <= 1'b0;
    end else if (state == IDLE && i_start && d_ok) begin
      range_q <= 1'b0;
    end else if (accept && i_coeff >= 12'd3329) begin
      range_q <= 1'b1;
    end
  end

  assign o_range_err = range_q;
`else
  assign o_range_err = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= IDLE;
      d        <= 4'd0;
      cnt      <= 8'd0;
      cnt_term <= 1'b0;
      r_vld    <= 1'b0;
      r_val    <= 11'd0;
      acc      <= 24'd0;
      fill     <= 5'd0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_err    <= 1'b0;
    end else begin
      o_done <= 1'b0;
      o_err  <= 1'b0;
      fill   <= fill_nxt;
      acc    <= acc_nxt;

      if (accept) begin
        r_vld <= 1'b1;
        r_val <= y;
      end else if (absorb) begin
        r_vld <= 1'b0;
      end

      if (accept) begin
        cnt <= cnt + 8'd1;
        if (cnt == 8'hFF) begin
          cnt_term <= 1'b1;
        end
      end

      unique case (state)
        IDLE: begin
          if (i_start) begin
            if (d_ok) begin
              d        <= i_d;
              cnt      <= 8'd0;
              cnt_term <= 1'b0;
              o_busy   <= 1'b1;
              state    <= RUN;
            end else begin
              o_err <= 1'b1;
            end
          end
        end
        RUN: begin
          if (accept && cnt == 8'hFF) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!r_vld && fill == 5'd0) begin
            o_busy <= 1'b0;
            o_done <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/compress_ctrl.md
COMPRESS_CTRL -- requirements
Module: compress_ctrl

Interface
REQ-001 SHALL have port i_clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port i_rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port i_start, input, 1, one-cycle job start; honoured only in IDLE.
REQ-004 SHALL have port i_d, input, 4, compression width d; sampled on accepted i_start.
REQ-005 SHALL have ports i_coeff (input, 12), i_coeff_valid (input, 1) and o_coeff_ready (output, 1), forming the coefficient stream; transfer when valid && ready.
REQ-006 SHALL have ports o_byte (output, 8), o_byte_valid (output, 1) and i_byte_ready (input, 1), forming the packed byte stream; transfer when valid && ready.
REQ-007 SHALL have outputs o_busy (1; high in RUN/DRAIN), o_done (1; one-cycle pulse at job end), o_err (1; one-cycle pulse on rejected start) and o_range_err (1; sticky range flag).

Function
REQ-008 SHALL run FSM states IDLE -> RUN -> DRAIN -> DONE -> IDLE.
REQ-009 SHALL treat i_start in IDLE with i_d in {1,4,5,10,11} as a job start: latch d, clear counters and o_range_err, go to RUN.
REQ-010 SHALL, on i_start in IDLE with any other i_d, stay in IDLE and pulse o_err the next cycle.
REQ-011 SHALL ignore i_start outside IDLE.
REQ-012 SHALL process exactly 256 coefficients per job, counted by an 8-bit counter plus a terminal flag (no wrap ambiguity).
REQ-013 SHALL compute each compressed value as y = ((x*K_d + 2^23) >> 24) mod 2^d, with K_d = 0x00275F (d=1), 0x013AFB (d=4), 0x0275F7 (d=5), 0x4EBEDE (d=10), 0x9D7DBB (d=11); the product is 36 bits wide.
REQ-014 SHALL register y in one pipeline stage (r_vld/r_val): a coefficient accepted in cycle t appears in r_val at t+1.
REQ-015 SHALL use a 24-bit LSB-first bit accumulator with a 5-bit fill count; r_val is absorbed when fill < 8, at bit position fill, and fill increases by d.
REQ-016 SHALL assert o_byte_valid whenever fill >= 8, with o_byte = acc[7:0]; on transfer, acc shifts right by 8 and fill decreases by 8.
REQ-017 SHALL apply absorb and byte transfer in the same cycle as net fill + d - 8, with shifted data merged at position fill - 8.
REQ-018 SHALL hold o_byte and o_byte_valid stable while i_byte_ready is low (no drop, no change).
REQ-019 SHALL assert o_coeff_ready = RUN && accepted < 256 && (!r_vld || absorb this cycle).
REQ-020 SHALL enter DRAIN after the 256th acceptance and DONE when r_vld == 0 and fill == 0; total output is exactly 32*d bytes (fill ends at 0).
REQ-021 SHALL pulse o_done for one cycle in DONE, then return to IDLE.

Reset
REQ-022 SHALL, on i_rst high at any time including mid-job, immediately return to IDLE and discard the job.
REQ-023 SHALL clear on reset: counters, fill, acc, r_vld; o_coeff_ready, o_byte_valid, o_busy, o_done, o_err and o_range_err = 0; o_byte = 0x00.

Configuration
REQ-024 SHALL, with COMPRESS_CTRL_RANGE_CHK_EN defined, set o_range_err when any accepted i_coeff >= 3329; the flag stays set until the next job start or reset, and data still flows unchanged.
REQ-025 SHALL, without COMPRESS_CTRL_RANGE_CHK_EN, keep port o_range_err and tie it to 0.

Verification
REQ-026 SHALL cover: d=1, all 256 coefficients = 1665 -> 32 bytes 0xFF, then one o_done pulse.
REQ-027 SHALL cover: d=4, coefficients alternating 0, 209 -> 128 bytes 0x10.
REQ-028 SHALL cover: d=10, all coefficients 0, i_byte_ready low for 10 cycles mid-job -> 320 bytes 0x00, o_byte held stable during the stall, no loss.
REQ-029 SHALL cover: i_start with i_d=7 -> o_err pulse, o_busy stays 0, no bytes output.
REQ-030 SHALL cover: reset asserted after 100 coefficients -> all outputs 0 next edge; a new d=5 job then yields exactly 160 bytes.
REQ-031 SHALL cover: with the macro defined, coefficient 3329 at index 5 -> o_range_err=1 until the next start; without the macro -> o_range_err stays 0.
